fm_demod: RTL and testbench
===========================

Name: fm_demod

Overview:
- FM quadrature demodulator. Sits directly upstream of the audio LPR FIR (decimate-by-8) and produces the demodulated sample stream that the FIR consumes.
- Pops one I/Q pair from the channel-filter output FIFOs and forms the conjugate product with the previous pair.
- Computes the phase angle with a fixed-point qarctan using a sequential divider, scales it by the demod gain, and pushes the result into the FIR input FIFO.

Parameters:
DATA_SIZE, 32, sample width (two's complement)
BITS, 10, fixed-point fraction bits (QUANT = 1024)
GAIN, 758, quantized demod gain
QUAD1, 804, quantized pi/4
QUAD3, 2412, quantized 3pi/4

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
real_empty  in  1  real-input FIFO empty
real_rd_en  out  1  real-input FIFO pop
real_dout  in  DATA_SIZE  real-input sample
imag_empty  in  1  imag-input FIFO empty
imag_rd_en  out  1  imag-input FIFO pop
imag_dout  in  DATA_SIZE  imag-input sample
demod_full  in  1  output FIFO full
demod_wr_en  out  1  output FIFO push
demod_din  out  DATA_SIZE  demodulated sample

Behaviour:
- Reset is asynchronous and active-low; clock is clock. While reset is low: all outputs 0, state S_READ, prev_real = prev_imag = 0, divider cleared.
- DEQ(v) is signed division by 2^BITS, truncating toward zero (not an arithmetic shift). Products are formed at 2*DATA_SIZE bits, dequantized, then truncated to DATA_SIZE. QUANTIZE_I is a left shift by BITS, wrapping at DATA_SIZE.
- S_READ:
  - Wait until real_empty = 0 and imag_empty = 0.
  - Then assert real_rd_en and imag_rd_en together for exactly one cycle and latch both dout values.
  - Never pop one FIFO without the other.
- S_MULT:
  - r = DEQ(prev_real*real) - DEQ(-prev_imag*imag)
  - i = DEQ(prev_real*imag) + DEQ(-prev_imag*real)
  - Update prev_real/prev_imag with the current sample.
- S_QSETUP: abs_y = |i| + 1.
  - x = r >= 0: num = QUANTIZE_I(r - abs_y), den = r + abs_y, base = QUAD1.
  - x < 0: num = QUANTIZE_I(r + abs_y), den = abs_y - r, base = QUAD3.
  - den >= 1 always.
- S_DIV:
  - Restoring divide of |num| by den, one quotient bit per cycle, exactly DATA_SIZE cycles.
  - Quotient sign = sign(num); result truncates toward zero.
- S_ANGLE: angle = base - DEQ(QUAD1*q); negate if i < 0.
- S_GAIN: out = DEQ(GAIN*angle).
- S_WRITE:
  - Hold while demod_full = 1.
  - When demod_full = 0, assert demod_wr_en for one cycle with demod_din = out, then return to S_READ.
- Latency with no stalls:
  - Pop at cycle 0, S_MULT at 1, S_QSETUP at 2, S_DIV at 3..34, S_ANGLE at 35, S_GAIN at 36, demod_wr_en at cycle 37.
  - Next pop no earlier than cycle 38.
- demod_din holds its value between pushes. demod_wr_en is never asserted while demod_full = 1.
- Reset asserted mid-computation aborts the sample. prev_* clear, and no partial push occurs after release.

Optional Feature:
- Macro FM_DEMOD_SAMPLE_CNT_EN.
- When defined: adds output port sample_count [31:0]. It resets to 0, increments by 1 on each cycle demod_wr_en = 1, and wraps 0xFFFFFFFF -> 0.
- When undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset with reset = 0 mid-run -> all outputs 0; after release, the first sample behaves as if prev = (0,0).
- First pair (1024,0) after reset (prev = 0: r = 0, i = 0) -> demod_din = 1190 (0x4A6); demod_wr_en 37 cycles after the pop.
- Sequence (1024,0), (1024,1024) -> second output 595 (0x253).
- Sequence (1024,0), (1024,1024), (1024,-1024) -> third output -1190 (0xFFFFFB5A); checks truncate-toward-zero, where a shift would give -1191.
- Append (-1024,0) -> fourth output -1785 (0xFFFFF907); exercises the x < 0 / QUAD3 path.
- Backpressure and empty inputs:
  - Hold demod_full = 1 for 20 cycles at S_WRITE -> demod_wr_en stays 0, then exactly one push.
  - Imag FIFO empty while real FIFO non-empty -> no rd_en on either FIFO.
  - With FM_DEMOD_SAMPLE_CNT_EN defined, sample_count equals the number of pushes.

Source files
------------

// File: rtl/fm_demod.sv
// fm_demod: FM quadrature demodulator (conjugate product, fixed-point qarctan via a
// restoring divider, demod gain). Define FM_DEMOD_SAMPLE_CNT_EN to add the sample_count port.
module fm_demod #(
    parameter int DATA_SIZE = 32,
    parameter int BITS      = 10,
    parameter int GAIN      = 758,
    parameter int QUAD1     = 804,
    parameter int QUAD3     = 2412
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 real_empty,
    output logic                 real_rd_en,
    input  logic [DATA_SIZE-1:0] real_dout,
    input  logic                 imag_empty,
    output logic                 imag_rd_en,
    input  logic [DATA_SIZE-1:0] imag_dout,
    input  logic                 demod_full,
    output logic                 demod_wr_en,
`ifdef FM_DEMOD_SAMPLE_CNT_EN
    output logic [31:0]          sample_count,
`endif
    output logic [DATA_SIZE-1:0] demod_din
);
    localparam int W2  = 2 * DATA_SIZE;
    localparam int CW  = $clog2(DATA_SIZE);
    localparam int MSB = DATA_SIZE - 1;

    typedef logic signed [DATA_SIZE-1:0] word_t;
    typedef logic signed [W2-1:0]        wide_t;

    typedef enum logic [2:0] {
        S_READ, S_MULT, S_QSETUP, S_DIV, S_ANGLE, S_GAIN, S_WRITE
    } state_t;

    // Divide by 2^BITS rounding toward zero: negative values are biased before the shift.
    function automatic wide_t deq(input wide_t v);
        wide_t bias;
        bias = v[W2-1] ? wide_t'((64'sd1 <<< BITS) - 64'sd1) : '0;
        return (v + bias) >>> BITS;
    endfunction

    function automatic word_t mulDeq(input word_t a, input word_t b);
        return word_t'(deq(wide_t'(a) * wide_t'(b)));
    endfunction

    state_t               state_q;
    word_t                curReal_q, curImag_q, prevReal_q, prevImag_q;
    word_t                r_q, i_q, den_q, base_q, angle_q, out_q;
    logic                 numNeg_q;
    logic [DATA_SIZE-1:0] dividend_q, rem_q, quot_q;
    logic [CW-1:0]        bitCnt_q;
    logic                 rdEn_q, wrEn_q;
    logic [DATA_SIZE-1:0] din_q;

    word_t                r_d, i_d, absY, num_d, den_d, base_d, angle_d, out_d;
    logic [DATA_SIZE-1:0] numMag_d, rem_d, quotSigned;
    logic [DATA_SIZE:0]   remShift;
    logic                 qBit_d;

    always_comb begin
        r_d = mulDeq(prevReal_q, curReal_q) - mulDeq(-prevImag_q, curImag_q);
        i_d = mulDeq(prevReal_q, curImag_q) + mulDeq(-prevImag_q, curReal_q);

        absY   = (i_q[MSB] ? -i_q : i_q) + word_t'(1);
        num_d  = '0;
        den_d  = word_t'(1);
        base_d = word_t'(QUAD1);
        if (!r_q[MSB]) begin
            num_d  = (r_q - absY) <<< BITS;
            den_d  = r_q + absY;
            base_d = word_t'(QUAD1);
        end else begin
            num_d  = (r_q + absY) <<< BITS;
            den_d  = absY - r_q;
            base_d = word_t'(QUAD3);
        end
        numMag_d = num_d[MSB] ? -num_d : num_d;

        // One restoring-division step on the unsigned magnitude.
        remShift = {rem_q, dividend_q[MSB]};
        qBit_d   = (remShift >= {1'b0, den_q});
        rem_d    = qBit_d ? DATA_SIZE'(remShift - {1'b0, den_q}) : remShift[DATA_SIZE-1:0];

        quotSigned = numNeg_q ? -quot_q : quot_q;
        angle_d    = base_q - mulDeq(word_t'(QUAD1), word_t'(quotSigned));
        if (i_q[MSB]) begin
            angle_d = -angle_d;
        end
        out_d = mulDeq(word_t'(GAIN), angle_q);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_READ;
            curReal_q  <= '0;
            curImag_q  <= '0;
            prevReal_q <= '0;
            prevImag_q <= '0;
            r_q        <= '0;
            i_q        <= '0;
            den_q      <= '0;
            base_q     <= '0;
            angle_q    <= '0;
            out_q      <= '0;
            numNeg_q   <= 1'b0;
            dividend_q <= '0;
            rem_q      <= '0;
            quot_q     <= '0;
            bitCnt_q   <= '0;
            rdEn_q     <= 1'b0;
            wrEn_q     <= 1'b0;
            din_q      <= '0;
        end else begin
            rdEn_q <= 1'b0;
            wrEn_q <= 1'b0;
            case (state_q)
                S_READ: begin
                    if (!real_empty && !imag_empty) begin
                        rdEn_q    <= 1'b1;
                        curReal_q <= word_t'(real_dout);
                        curImag_q <= word_t'(imag_dout);
                        state_q   <= S_MULT;
                    end
                end
                S_MULT: begin
                    r_q        <= r_d;
                    i_q        <= i_d;
                    prevReal_q <= curReal_q;
                    prevImag_q <= curImag_q;
                    state_q    <= S_QSETUP;
                end
                S_QSETUP: begin
                    den_q      <= den_d;
                    base_q     <= base_d;
                    numNeg_q   <= num_d[MSB];
                    dividend_q <= numMag_d;
                    rem_q      <= '0;
                    quot_q     <= '0;
                    bitCnt_q   <= CW'(DATA_SIZE - 1);
                    state_q    <= S_DIV;
                end
                S_DIV: begin
                    rem_q      <= rem_d;
                    quot_q     <= {quot_q[DATA_SIZE-2:0], qBit_d};
                    dividend_q <= {dividend_q[DATA_SIZE-2:0], 1'b0};
                    if (bitCnt_q == '0) begin
                        state_q <= S_ANGLE;
                    end else begin
                        bitCnt_q <= bitCnt_q - CW'(1);
                    end
                end
                S_ANGLE: begin
                    angle_q <= angle_d;
                    state_q <= S_GAIN;
                end
                S_GAIN: begin
                    out_q   <= out_d;
                    state_q <= S_WRITE;
                end
                S_WRITE: begin
                    if (!demod_full) begin
                        wrEn_q  <= 1'b1;
                        din_q   <= out_q;
                        state_q <= S_READ;
                    end
                end
                default: state_q <= S_READ;
            endcase
        end
    end

    // Both FIFOs share one pop strobe so they can never drift apart.
    assign real_rd_en  = rdEn_q;
    assign imag_rd_en  = rdEn_q;
    assign demod_wr_en = wrEn_q;
    assign demod_din   = din_q;

`ifdef FM_DEMOD_SAMPLE_CNT_EN
    logic [31:0] sampleCnt_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sampleCnt_q <= '0;
        end else if (wrEn_q) begin
            sampleCnt_q <= sampleCnt_q + 32'd1;
        end
    end

    assign sample_count = sampleCnt_q;
`endif

endmodule

// File: tb/tb_fm_demod.sv
// tb_fm_demod: self-checking bench for fm_demod -- reference vectors, backpressure,
// empty-FIFO gating, mid-run reset and random pairs against an arithmetic model.
module tb_fm_demod;
    localparam longint QUANT = 1024;
    localparam int     GAIN  = 758;
    localparam int     QUAD1 = 804;
    localparam int     QUAD3 = 2412;

    logic        clock = 1'b0;
    logic        reset;
    logic        real_empty, real_rd_en, imag_empty, imag_rd_en;
    logic        demod_full, demod_wr_en;
    logic [31:0] real_dout, imag_dout, demod_din;
`ifdef FM_DEMOD_SAMPLE_CNT_EN
    logic [31:0] sample_count;
`endif

    always #5 clock = ~clock;

    fm_demod dut (
        .clock       (clock),
        .reset       (reset),
        .real_empty  (real_empty),
        .real_rd_en  (real_rd_en),
        .real_dout   (real_dout),
        .imag_empty  (imag_empty),
        .imag_rd_en  (imag_rd_en),
        .imag_dout   (imag_dout),
        .demod_full  (demod_full),
        .demod_wr_en (demod_wr_en),
`ifdef FM_DEMOD_SAMPLE_CNT_EN
        .sample_count(sample_count),
`endif
        .demod_din   (demod_din)
    );

    // First-word-fall-through FIFO models feeding the DUT.
    logic [31:0] realMem [0:255];
    logic [31:0] imagMem [0:255];
    int realWr = 0, realRd = 0, imagWr = 0, imagRd = 0;

    assign real_empty = (realRd == realWr);
    assign imag_empty = (imagRd == imagWr);
    assign real_dout  = realMem[realRd[7:0]];
    assign imag_dout  = imagMem[imagRd[7:0]];

    always @(posedge clock) begin
        if (real_rd_en && realRd != realWr) realRd <= realRd + 1;
        if (imag_rd_en && imagRd != imagWr) imagRd <= imagRd + 1;
    end

    // Output-side monitor, sampled on the falling edge.
    int cycleCnt = 0, pushCount = 0, pushSinceReset = 0, rdCount = 0;
    int lastRdCycle = -1, lastWrCycle = -1, minRdGap = 1000000;
    int fullViol = 0, rdSplit = 0, holdViol = 0, heldDin = 0;
    int outQ[$];

    always @(negedge clock) begin
        cycleCnt++;
        if (real_rd_en != imag_rd_en) rdSplit++;
        if (real_rd_en) begin
            if (lastRdCycle >= 0 && cycleCnt - lastRdCycle < minRdGap) minRdGap = cycleCnt - lastRdCycle;
            lastRdCycle = cycleCnt;
            rdCount++;
        end
        if (!reset) begin
            heldDin = 0;
            pushSinceReset = 0;
        end else if (demod_wr_en) begin
            if (demod_full) fullViol++;
            pushCount++;
            pushSinceReset++;
            lastWrCycle = cycleCnt;
            heldDin = int'(demod_din);
            outQ.push_back(int'(demod_din));
        end else if (int'(demod_din) != heldDin) begin
            holdViol++;
        end
    end

    int checks = 0, passed = 0;
    int modelPrevR = 0, modelPrevI = 0;
    int expQ[$];

    function automatic int deqM(input longint v);
        return int'(v / QUANT);
    endfunction

    // Reference: conjugate product, qarctan with a true division, then gain.
    function automatic int modelOut(input int pr, input int pi, input int cr, input int ci);
        int r, i, absY, num, den, base, q, angle;
        r = deqM(longint'(pr) * longint'(cr)) - deqM(-longint'(pi) * longint'(ci));
        i = deqM(longint'(pr) * longint'(ci)) + deqM(-longint'(pi) * longint'(cr));
        absY = ((i < 0) ? -i : i) + 1;
        if (r >= 0) begin
            num = (r - absY) * int'(QUANT); den = r + absY; base = QUAD1;
        end else begin
            num = (r + absY) * int'(QUANT); den = absY - r; base = QUAD3;
        end
        q = num / den;
        angle = base - deqM(longint'(QUAD1) * longint'(q));
        if (i < 0) angle = -angle;
        return deqM(longint'(GAIN) * longint'(angle));
    endfunction

    function automatic int randSample();
        return int'($urandom_range(8192, 0)) - 4096;
    endfunction

    task automatic pushReal(input int v);
        realMem[realWr[7:0]] = v;
        realWr++;
    endtask

    task automatic pushImag(input int v);
        imagMem[imagWr[7:0]] = v;
        imagWr++;
    endtask

    task automatic modelStep(input int re, input int im);
        expQ.push_back(modelOut(modelPrevR, modelPrevI, re, im));
        modelPrevR = re;
        modelPrevI = im;
    endtask

    task automatic applyStimulus(input int re, input int im);
        pushReal(re);
        pushImag(im);
        modelStep(re, im);
    endtask

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual == expected) passed++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    task automatic waitPush(input string name, input int budget, output bit ok, output int value);
        int n = 0;
        while (outQ.size() == 0 && n < budget) begin
            @(negedge clock);
            n++;
        end
        ok = (outQ.size() != 0);
        if (ok) begin
            value = outQ.pop_front();
        end else begin
            value = 0;
            checks++;
            $display("[TB] FAIL %s: no push within %0d cycles", name, budget);
        end
    endtask

    task automatic checkNext(input string name);
        bit ok;
        int v, e;
        e = (expQ.size() != 0) ? expQ.pop_front() : 0;
        waitPush(name, 300, ok, v);
        if (ok) checkOutput(name, v, e);
    endtask

    typedef struct {
        int re;
        int im;
        int expOut;
    } vec_t;

    initial begin
        vec_t vecs[4];
        bit   ok;
        int   v, base, rdBase;

        vecs[0] = '{re: 1024,  im: 0,     expOut: 1190};
        vecs[1] = '{re: 1024,  im: 1024,  expOut: 595};
        vecs[2] = '{re: 1024,  im: -1024, expOut: -1190};
        vecs[3] = '{re: -1024, im: 0,     expOut: -1785};

        reset = 1'b0;
        demod_full = 1'b0;
        repeat (3) @(negedge clock);
        checkOutput("reset_real_rd_en", real_rd_en, 0);
        checkOutput("reset_imag_rd_en", imag_rd_en, 0);
        checkOutput("reset_wr_en", demod_wr_en, 0);
        checkOutput("reset_din", int'(demod_din), 0);
        reset = 1'b1;
        @(negedge clock);

        for (int k = 0; k < 4; k++) begin
            pushReal(vecs[k].re);
            pushImag(vecs[k].im);
            waitPush($sformatf("vec_%0d", k), 300, ok, v);
            if (ok) checkOutput($sformatf("vec_%0d", k), v, vecs[k].expOut);
            if (k == 0) checkOutput("first_latency", lastWrCycle - lastRdCycle, 37);
        end
        modelPrevR = -1024;
        modelPrevI = 0;

        // Backpressure: output FIFO full well past the point the result is ready.
        demod_full = 1'b1;
        base = pushCount;
        applyStimulus(300, 700);
        repeat (60) @(negedge clock);
        checkOutput("bp_no_push", pushCount - base, 0);
        demod_full = 1'b0;
        checkNext("bp_value");
        repeat (40) @(negedge clock);
        checkOutput("bp_single_push", pushCount - base, 1);

        // Imag FIFO empty while real has data: nothing may be popped.
        rdBase = rdCount;
        pushReal(500);
        repeat (50) @(negedge clock);
        checkOutput("imag_empty_no_pop", rdCount - rdBase, 0);
        pushImag(-300);
        modelStep(500, -300);
        checkNext("imag_empty_value");

        for (int k = 0; k < 16; k++) applyStimulus(randSample(), randSample());
        for (int k = 0; k < 16; k++) checkNext($sformatf("rand_%0d", k));
        checkOutput("pop_gap", minRdGap, 38);

        // Reset in the middle of a divide aborts the sample and clears history.
        rdBase = rdCount;
        pushReal(2000);
        pushImag(-1500);
        for (int n = 0; n < 20 && rdCount == rdBase; n++) @(negedge clock);
        checkOutput("reset_test_pop", rdCount - rdBase, 1);
        repeat (15) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        checkOutput("midreset_rd_en", real_rd_en, 0);
        checkOutput("midreset_wr_en", demod_wr_en, 0);
        checkOutput("midreset_din", int'(demod_din), 0);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        base = pushCount;
        repeat (60) @(negedge clock);
        checkOutput("reset_no_partial_push", pushCount - base, 0);
        modelPrevR = 0;
        modelPrevI = 0;
        applyStimulus(1024, 0);
        checkNext("post_reset_first");

        repeat (5) @(negedge clock);
        checkOutput("full_violation", fullViol, 0);
        checkOutput("rd_en_paired", rdSplit, 0);
        checkOutput("din_hold", holdViol, 0);
`ifdef FM_DEMOD_SAMPLE_CNT_EN
        checkOutput("sample_count", sample_count, pushSinceReset);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
